// File: rtl/core_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store request unit.
package core_lsu_pkg;

  localparam int unsigned LSU_XLEN = 32;

  // Access size encodings, shared with the writeback load extractor
  localparam logic [3:0] SIZE_BYTE = 4'b0001;
  localparam logic [3:0] SIZE_HALF = 4'b0011;
  localparam logic [3:0] SIZE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/core_store_align.sv
// Byte-enable generation, store-data lane replication and misalignment detection.
module core_store_align
  import core_lsu_pkg::*;
#(
  parameter int unsigned XLEN = LSU_XLEN
) (
  input  logic [3:0]      i_d_size,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_wdata,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic            o_misaligned
);

  // Unknown size encodings fall through to word behaviour
  always_comb begin
    o_be         = 4'b1111;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    case (i_d_size)
      SIZE_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = XLEN'({4{i_wdata[7:0]}});
      end
      SIZE_HALF: begin
        o_be         = 4'b0011 << i_addr_lo;
        o_wdata      = XLEN'({2{i_wdata[15:0]}});
        o_misaligned = i_addr_lo[0];
      end
      default: begin
        o_misaligned = |i_addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/core_lsu_req.sv
// MEM-stage load/store request unit: turns pipeline ops into word-aligned
// req/gnt/rvalid bus transactions, one outstanding at a time.
module core_lsu_req
  import core_lsu_pkg::*;
#(
  parameter int unsigned XLEN = LSU_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic [3:0]      i_d_size,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_data_req,
  output logic            o_data_we,
  output logic [XLEN-1:0] o_data_addr,
  output logic [3:0]      o_data_be,
  output logic [XLEN-1:0] o_data_wdata,
  input  logic            i_data_gnt,
  input  logic            i_data_rvalid,
  input  logic [XLEN-1:0] i_data_rdata,
  output logic [XLEN-1:0] o_load_data,
  output logic            o_stall,
  output logic            o_misaligned
);

  lsu_state_t      state_q;
  lsu_state_t      state_d;
  logic            op_c;
  logic            accept_c;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic            al_mis;

  assign op_c = i_mem_read | i_mem_write;

  core_store_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_d_size     (i_d_size),
    .i_addr_lo    (i_addr[1:0]),
    .i_wdata      (i_wdata),
    .o_be         (al_be),
    .o_wdata      (al_wdata),
    .o_misaligned (al_mis)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an op is only looked at while idle
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_c && !al_mis) begin
          accept_c = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_data_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_data_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stall drops in the rvalid cycle so the pipeline advances on that edge
  assign o_stall = accept_c
                 | (state_q == ST_REQ)
                 | ((state_q == ST_WAIT) & ~i_data_rvalid);

  // Misaligned ops are reported for the cycle they are presented, never issued
  assign o_misaligned = i_rst_n & (state_q == ST_IDLE) & op_c & al_mis;

  // Bus request capture and load-data return
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_data_req   <= 1'b0;
      o_data_we    <= 1'b0;
      o_data_addr  <= '0;
      o_data_be    <= 4'b0000;
      o_data_wdata <= '0;
      o_load_data  <= '0;
    end else begin
      if (accept_c) begin
        o_data_req   <= 1'b1;
        o_data_we    <= i_mem_write;
        o_data_addr  <= {i_addr[XLEN-1:2], 2'b00};
        o_data_be    <= al_be;
        o_data_wdata <= al_wdata;
      end
      if ((state_q == ST_REQ) && i_data_gnt) begin
        o_data_req <= 1'b0;
      end
      if ((state_q == ST_WAIT) && i_data_rvalid && !o_data_we) begin
        o_load_data <= i_data_rdata;
      end
    end
  end

endmodule

// File: doc/core_lsu_req.md
Name: core_lsu_req

Overview:
- MEM-stage load/store request unit; the write-direction counterpart of the writeback load extractor.
- Converts pipeline load/store ops into word-aligned data-bus requests: byte enables, lane-replicated store data, req/gnt/rvalid handshake.
- Stalls the pipeline while a transaction is outstanding.
- Flags misaligned accesses without issuing them.
- Raw read word is returned unmodified; byte/half extraction and sign extension stay in writeback.

Parameters:
XLEN, 32, data/address width; only 32 is supported.

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  synchronous reset, active-low
i_mem_read  in  1  load op valid this cycle
i_mem_write  in  1  store op valid this cycle
i_d_size  in  4  0001 byte, 0011 half, 1111 word (other values treated as word)
i_addr  in  XLEN  byte address (ALU result)
i_wdata  in  XLEN  store data, right-justified
o_data_req  out  1  bus request
o_data_we  out  1  1 = write
o_data_addr  out  XLEN  word address, bits [1:0] forced to 0
o_data_be  out  4  byte enables
o_data_wdata  out  XLEN  lane-positioned store data
i_data_gnt  in  1  request accepted
i_data_rvalid  in  1  response valid (reads and writes)
i_data_rdata  in  XLEN  read word
o_load_data  out  XLEN  last read word, held
o_stall  out  1  hold upstream pipeline
o_misaligned  out  1  one-cycle misalignment pulse

Behaviour:
- FSM states: IDLE, REQ, WAIT. Reset (i_rst_n=0 at a clock edge) → IDLE.
- Reset values: all bus outputs 0, o_load_data 0, o_misaligned 0.
- Reset mid-transaction: abandon the transaction, drop o_data_req next cycle, ignore any later gnt/rvalid.
- Op valid: op = i_mem_read | i_mem_write. Both high counts as a store.
- Misaligned when:
  - half with addr[0]=1, or
  - word with addr[1:0]≠0.
- Alignment, from addr[1:0]:
  - byte: be = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - half: be = 0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - word: be = 1111, wdata unchanged.
  - Loads use the same be; wdata is don't-care.
- IDLE:
  - Aligned op: register addr, we, be, wdata; go to REQ; o_stall=1 combinationally this cycle.
  - Misaligned op: o_misaligned=1 for that cycle only, no request, no stall, stay in IDLE.
- REQ:
  - o_data_req=1 with addr, we, be, wdata stable.
  - On i_data_gnt go to WAIT; req drops the next cycle.
  - gnt may arrive any number of cycles later; hold everything until it does.
- WAIT:
  - On i_data_rvalid: if the access is a load, capture i_data_rdata into o_load_data (visible next cycle); go to IDLE.
  - rvalid in REQ, or in IDLE, is ignored (protocol violation).
- o_stall = (IDLE & aligned op) | REQ | (WAIT & ~i_data_rvalid).
  - Stall therefore drops in the rvalid cycle, so the pipeline advances that edge.
  - A new op can be accepted in the following IDLE cycle. Minimum op-to-op spacing: 3 cycles with 0-wait gnt and rvalid.
- Single outstanding transaction only. Inputs are ignored outside IDLE; the stall guarantees they are stable.
- o_load_data holds its value until the next load completes.

Decomposition:
- Package core_lsu_pkg:
  - size localparams SIZE_BYTE, SIZE_HALF, SIZE_WORD, shared with the writeback stage;
  - FSM state enum lsu_state_t.
- Sub-module core_store_align: combinational; i_d_size, i_addr[1:0], i_wdata → be, aligned wdata, misaligned.
- Top: FSM, capture registers, stall logic.

Test Plan:
- Store byte: addr=0x1003, wdata=0x000000A5; gnt and rvalid each 1 cycle later → addr 0x1000, be 1000, wdata 0xA5A5A5A5, we=1; stall high 3 cycles total.
- Load half: addr=0x2002, gnt delayed 4 cycles, i_data_rdata=0xBEEF1234 → req held 5 cycles with be 1100, fields stable; o_load_data=0xBEEF1234 after rvalid.
- Misaligned: word at 0x3001 and half at 0x3003 → o_misaligned one-cycle pulse each, o_data_req never asserted, o_stall stays 0.
- Back-to-back: word store at 0x40, then word load at 0x44, zero-wait bus → two requests 3 cycles apart; be 1111 on both; second request has we=0.
- Reset in WAIT: i_rst_n=0 for one edge, then rvalid arrives → state IDLE, o_load_data=0, o_stall=0, late rvalid ignored.
- Invalid size 4'b0101 at addr 0x10 → treated as word: be 1111, no misalignment pulse.
